// File: rtl/violet_pkg.sv
// rtl/violet_pkg.sv - shared constants and state encodings for the Violet button receiver
package violet_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  typedef enum logic [1:0] {HDR, LO, HI, CHK} parse_state_t;

endpackage

// File: rtl/violet_uart_rx_byte.sv
// rtl/violet_uart_rx_byte.sv - 8N1 byte receiver with two-flop input synchroniser
module violet_uart_rx_byte
  import violet_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       fe
);

  localparam int CW = $clog2(BAUD_DIV);

  logic            sync1;
  logic            sync2;
  logic            line_d;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            tick;

  assign tick = (cnt == '0);

  always_ff @(posedge i_clk) begin
    if (rst) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      line_d     <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      fe         <= 1'b0;
    end else begin
      sync1      <= uart_rx;
      sync2      <= sync1;
      line_d     <= sync2;
      byte_valid <= 1'b0;
      fe         <= 1'b0;
      case (state)
        IDLE: begin
          // Only a genuine falling edge arms the receiver; a held-low line is ignored.
          if (line_d && !sync2) begin
            state <= START;
            cnt   <= CW'(BAUD_DIV / 2 - 1);
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (sync2) begin
            state <= IDLE;
          end else begin
            state   <= DATA;
            cnt     <= CW'(BAUD_DIV - 1);
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {sync2, shreg[7:1]};
            cnt   <= CW'(BAUD_DIV - 1);
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (sync2) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              fe <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/violet_button_rx.sv
// rtl/violet_button_rx.sv - button frame parser with checksum and inter-byte timeout
module violet_button_rx
  import violet_pkg::*;
#(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [15:0] buttons,
  output logic        frame_ok,
  output logic        err
);

  localparam int TLIM = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW   = $clog2(TLIM + 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          fe;
  parse_state_t  state;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic [TW-1:0] timer;
  logic          expire;

  violet_uart_rx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .i_clk     (i_clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .fe        (fe)
  );

  // timer holds cycles elapsed since the last byte_valid, so it reaches TLIM
  // on the same edge that the timeout err is registered.
  assign expire = (state != HDR) && (timer == TW'(TLIM - 1));

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state    <= HDR;
      lo_q     <= '0;
      hi_q     <= '0;
      timer    <= '0;
      buttons  <= '0;
      frame_ok <= 1'b0;
      err      <= 1'b0;
    end else begin
      frame_ok <= 1'b0;
      err      <= 1'b0;

      if (byte_valid) timer <= TW'(1);
      else if (state != HDR && timer != TW'(TLIM)) timer <= timer + TW'(1);

      if (fe) begin
        err   <= 1'b1;
        state <= HDR;
      end else if (byte_valid) begin
        case (state)
          HDR: if (byte_data == FRAME_HDR) state <= LO;
          LO: begin
            lo_q  <= byte_data;
            state <= HI;
          end
          HI: begin
            hi_q  <= byte_data;
            state <= CHK;
          end
          CHK: begin
            if (byte_data == (FRAME_HDR ^ lo_q ^ hi_q)) begin
              buttons  <= {hi_q, lo_q};
              frame_ok <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state <= HDR;
          end
          default: state <= HDR;
        endcase
      end else if (expire) begin
        err   <= 1'b1;
        state <= HDR;
      end
    end
  end

endmodule

// File: tb/tb_violet_button_rx.sv
// tb/tb_violet_button_rx.sv - directed self-checking bench for violet_button_rx
module tb_violet_button_rx;

  localparam int BD = 4;

  logic        i_clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [15:0] buttons;
  logic        frame_ok;
  logic        err;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          ok_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          ok_cyc = 0;
  int          err_cyc = 0;
  logic [15:0] ok_btn = '0;
  int          last_start = 0;
  int          ok0;
  int          err0;

  violet_button_rx #(
    .BAUD_DIV    (BD),
    .TIMEOUT_BITS(40)
  ) dut (
    .i_clk   (i_clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .buttons (buttons),
    .frame_ok(frame_ok),
    .err     (err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!rst) begin
      if (frame_ok) begin
        ok_cnt <= ok_cnt + 1;
        ok_cyc <= cyc;
        ok_btn <= buttons;
      end
      if (err) begin
        err_cnt <= err_cnt + 1;
        err_cyc <= cyc;
      end
      if (frame_ok && err) both_cnt <= both_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Entered just after a posedge; drives one 8N1 character with no trailing idle.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx    = 1'b0;
    last_start = cyc;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BD);
    end
    uart_rx = stop;
    tick(BD);
    uart_rx = 1'b1;
  endtask

  task automatic snap();
    ok0  = ok_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    tick(5);
    check("rst_buttons", 32'(buttons), 32'h0);
    check("rst_frame_ok", 32'(frame_ok), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    tick(200);
    check("idle_ok", 32'(ok_cnt), 32'd0);
    check("idle_err", 32'(err_cnt), 32'd0);
    check("idle_buttons", 32'(buttons), 32'h0);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h83, 1'b1);
    tick(10);
    check("f1_ok", 32'(ok_cnt - ok0), 32'd1);
    check("f1_err", 32'(err_cnt - err0), 32'd0);
    check("f1_btn_at_pulse", 32'(ok_btn), 32'h1234);
    check("f1_buttons", 32'(buttons), 32'h1234);
    check("f1_latency", 32'(ok_cyc - last_start), 32'd42);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(10);
    check("badchk_err", 32'(err_cnt - err0), 32'd1);
    check("badchk_ok", 32'(ok_cnt - ok0), 32'd0);
    check("badchk_keep", 32'(buttons), 32'h1234);
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b1);
    tick(10);
    check("f2_ok", 32'(ok_cnt - ok0), 32'd1);
    check("f2_buttons", 32'(buttons), 32'h00FF);

    snap();
    send_byte(8'h00, 1'b1);
    send_byte(8'h7E, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'hA6, 1'b1);
    tick(10);
    check("resync_err", 32'(err_cnt - err0), 32'd0);
    check("resync_ok", 32'(ok_cnt - ok0), 32'd1);
    check("resync_buttons", 32'(buttons), 32'h0201);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    tick(200);
    check("tmo_err", 32'(err_cnt - err0), 32'd1);
    check("tmo_when", 32'(err_cyc - last_start), 32'd201);
    check("tmo_ok", 32'(ok_cnt - ok0), 32'd0);
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h8B, 1'b1);
    tick(10);
    check("after_tmo_ok", 32'(ok_cnt - ok0), 32'd1);
    check("after_tmo_buttons", 32'(buttons), 32'h5678);

    snap();
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(60);
    check("glitch_err", 32'(err_cnt - err0), 32'd0);
    check("glitch_ok", 32'(ok_cnt - ok0), 32'd0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h25, 1'b1);
    tick(10);
    check("glitch_then_frame", 32'(buttons), 32'h8000);

    snap();
    send_byte(8'hA5, 1'b0);
    tick(20);
    check("fe_err", 32'(err_cnt - err0), 32'd1);
    check("fe_when", 32'(err_cyc - last_start), 32'd42);
    check("fe_ok", 32'(ok_cnt - ok0), 32'd0);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(5);
    rst = 1'b1;
    tick(2);
    check("midrst_buttons", 32'(buttons), 32'h0);
    rst = 1'b0;
    tick(1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h96, 1'b1);
    tick(10);
    check("midrst_ok", 32'(ok_cnt - ok0), 32'd0);
    check("midrst_err", 32'(err_cnt - err0), 32'd0);
    check("midrst_buttons_end", 32'(buttons), 32'h0);

    check("never_both", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/violet_button_rx.md
# violet_button_rx

Receive-side stage of the Violet virtual I/O link. It deserialises 8N1 UART bytes from the host on `uart_rx` and parses fixed 4-byte button frames. It validates each frame and presents the latest valid 16-bit button state to user logic. It sits between the `uart_rx` pin and the `buttons` bus consumed by designs such as the LED chaser.

## Interface
- `BAUD_DIV`, 2604, clock cycles per UART bit (25 MHz / 9600); minimum 4, even values only.
- `TIMEOUT_BITS`, 40, maximum gap between bytes of one frame, measured in bit times.
- `i_clk` in 1, sole clock.
- `rst` in 1, synchronous, active-high reset.
- `uart_rx` in 1, asynchronous serial input; idles high.
- `buttons` out 16, last accepted button state.
- `frame_ok` out 1, one-cycle pulse; high in the cycle `buttons` updates.
- `err` out 1, one-cycle pulse on a checksum, framing or timeout error.

## Operation
- Input sync: two flops; both reset to 1. All logic uses the second flop.
- Byte receiver FSM states:
  - IDLE: a high→low transition of the synced line starts a byte. Go to START and load the bit counter with BAUD_DIV/2−1.
  - START: when the counter reaches 0, sample the line. If it is 1, this is a false start; return to IDLE with no pulse. If it is 0, go to DATA.
  - DATA: sample every BAUD_DIV cycles. Collect 8 bits, LSB first, then go to STOP.
  - STOP: sample after BAUD_DIV cycles.
    - If the sample is 1, pulse internal `byte_valid` with `byte_data`.
    - If it is 0, pulse internal `fe`.
    - Either way, return to IDLE. A new start needs a fresh falling edge, so a held-low break never retriggers.
- Frame format: `0xA5`, `lo`, `hi`, `chk`, where chk = 0xA5 ^ lo ^ hi.
- Frame parser FSM states:
  - HDR: a byte equal to 0xA5 goes to LO. Any other byte is silently discarded and the FSM stays in HDR (resync, no `err`).
  - LO: latch the byte, go to HI.
  - HI: latch the byte, go to CHK.
  - CHK: if the checksum matches, set `buttons` ← {hi, lo} and pulse `frame_ok`. If not, pulse `err` and leave `buttons` unchanged. Either way, go to HDR.
- `fe` in any parser state: pulse `err` and go to HDR. In HDR, `fe` also pulses `err`.
- Timeout counter:
  - Cleared on every `byte_valid`.
  - Counts only while the parser is in LO, HI or CHK.
  - Reaching TIMEOUT_BITS·BAUD_DIV pulses `err` and sends the parser to HDR.
  - Width is sized by $clog2(TIMEOUT_BITS·BAUD_DIV+1); it saturates and never wraps.
- Simultaneous timeout expiry and `byte_valid` in the same cycle: the byte wins. Process the byte and clear the timer, with no `err`.
- `frame_ok` and `err` are never high in the same cycle.
- Reset, applied at any time:
  - `buttons` = 0x0000, `frame_ok` = 0, `err` = 0.
  - Both FSMs return to IDLE/HDR, counters are cleared, and any partial byte or frame is discarded.
  - Reset mid-byte: the receiver re-arms only on the next falling edge.

## Timing
- Samples are taken at bit centres. Relative to the synced falling edge at cycle 0:
  - start bit is sampled at BAUD_DIV/2;
  - data bit k is sampled at BAUD_DIV/2 + (k+1)·BAUD_DIV;
  - stop bit is sampled at BAUD_DIV/2 + 9·BAUD_DIV.
- `byte_valid` is registered one cycle after the stop sample.
- The parser acts on `byte_valid` with one register stage. `buttons`, `frame_ok` and `err` all change in the cycle after `byte_valid` of the deciding byte.
- The pin-to-edge latency adds 2 cycles for the synchroniser.
- Throughput: back-to-back bytes with zero idle time between stop and next start must be received. The receiver is in IDLE before the next start edge can occur.

## Structure
- Package `violet_pkg` holds:
  - `FRAME_HDR` = 8'hA5;
  - the `rx_state_t` enum {IDLE, START, DATA, STOP};
  - the `parse_state_t` enum {HDR, LO, HI, CHK}.
- Sub-module `violet_uart_rx_byte` contains the synchroniser, the byte FSM and the bit counter. Its outputs are `byte_valid`, `byte_data[7:0]` and `fe`.
- The top `violet_button_rx` contains the parser, checksum and timeout logic.

## Test plan
Use BAUD_DIV=4 and TIMEOUT_BITS=40 for all scenarios.
- Reset, then line idle for 200 cycles → `buttons`=0x0000, no `frame_ok` or `err` pulses.
- Send A5 34 12 83 back-to-back → one `frame_ok` pulse and `buttons`=0x1234 in the same cycle. The update occurs 2 + 2 + 9·4 + 1 + 1 cycles after the last start edge.
- Send A5 34 12 00 → one `err` pulse and `buttons` keeps its previous value. Then send a valid A5 FF 00 5A → `buttons`=0x00FF.
- Send 00 7E A5 01 02 A6 → the junk bytes are ignored with no `err`, then `buttons`=0x0201.
- Send A5 01, then idle for 200 cycles → exactly one `err` at 160 cycles after the `byte_valid` of 01, parser returns to HDR. Then send a valid frame → it is accepted.
- Glitch: a 1-cycle low pulse on `uart_rx` → no byte and no `err`.
- Stop bit forced 0 on a header byte → one `err` pulse.
- Assert `rst` after byte 2 of a frame, then complete the remaining bytes → no `frame_ok` and `buttons`=0.
